// File: rtl/fetch_pc_gen.sv
// Instruction-fetch PC generator: issues icache fetch addresses, applies flush/branch
// redirects (captured even under stall), bounds outstanding fetches and tags requests with an epoch.
module fetch_pc_gen #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hbfc00000,
  parameter int                FETCH_BYTES  = 4,
  parameter int                MAX_OUTST    = 4,
  parameter int                EPOCH_W      = 2,
  localparam int               CNT_W        = $clog2(MAX_OUTST + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               req_valid,
  output logic [ADDR_W-1:0]  req_pc,
  output logic [EPOCH_W-1:0] req_epoch,
  output logic               req_misalign,
  input  logic               addr_ok,
  input  logic               resp_valid,
  output logic [CNT_W-1:0]   outst_cnt
);

  logic [ADDR_W-1:0]  pc_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               started_q;

  logic [ADDR_W-1:0]  tgt;
  logic               redirect;
  logic               fire;

  // Redirect bypass: a flush or branch is presented to the icache in the same cycle it arrives.
  always_comb begin
    tgt = pc_q;
    if (flush) begin
      tgt = new_pc;
    end else if (branch_valid) begin
      tgt = branch_target;
    end
  end

  assign redirect     = flush | (branch_valid & ~stall);
  assign req_pc       = tgt;
  assign req_epoch    = redirect ? epoch_q + EPOCH_W'(1) : epoch_q;
  assign req_valid    = started_q & (cnt_q < CNT_W'(MAX_OUTST)) & (~stall | flush);
  assign req_misalign = req_valid & (req_pc[1:0] != 2'b00);
  assign fire         = req_valid & addr_ok;
  assign outst_cnt    = cnt_q;

  // A stalled branch still updates pc_q and bumps the epoch, so the release issues the target without a second bump.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_VECTOR;
      epoch_q   <= '0;
      cnt_q     <= '0;
      started_q <= 1'b0;
    end else begin
      started_q <= 1'b1;

      if (fire) begin
        pc_q <= tgt + ADDR_W'(FETCH_BYTES);
      end else if (flush) begin
        pc_q <= new_pc;
      end else if (branch_valid) begin
        pc_q <= branch_target;
      end

      if (flush | branch_valid) begin
        epoch_q <= epoch_q + EPOCH_W'(1);
      end

      if (fire & ~resp_valid) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (resp_valid & ~fire & (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_pc_gen;

  localparam int          ADDR_W       = 32;
  localparam int          EPOCH_W      = 2;
  localparam int          MAX_OUTST    = 4;
  localparam int          FETCH_BYTES  = 4;
  localparam int          CNT_W        = 3;
  localparam logic [31:0] RESET_VECTOR = 32'hbfc00000;

  logic               clk = 1'b0;
  logic               rst, stall, flush, branch_valid, addr_ok, resp_valid;
  logic [ADDR_W-1:0]  new_pc, branch_target, req_pc;
  logic               req_valid, req_misalign;
  logic [EPOCH_W-1:0] req_epoch;
  logic [CNT_W-1:0]   outst_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  logic [ADDR_W-1:0]  m_pc      = RESET_VECTOR;
  logic [EPOCH_W-1:0] m_epoch   = '0;
  int                 m_cnt     = 0;
  bit                 m_started = 1'b0;

  fetch_pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .req_valid(req_valid), .req_pc(req_pc), .req_epoch(req_epoch),
    .req_misalign(req_misalign), .addr_ok(addr_ok), .resp_valid(resp_valid),
    .outst_cnt(outst_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [ADDR_W-1:0] m_tgt();
    return flush ? new_pc : (branch_valid ? branch_target : m_pc);
  endfunction

  function automatic bit m_valid();
    return m_started && (m_cnt < MAX_OUTST) && (!stall || flush);
  endfunction

  function automatic logic [EPOCH_W-1:0] m_req_epoch();
    logic [EPOCH_W-1:0] e;
    e = m_epoch;
    if (flush || (branch_valid && !stall)) e = e + 1'b1;
    return e;
  endfunction

  // Advance one clock edge; the model consumes the inputs sampled at that edge.
  task automatic tick();
    bit fire;
    logic [ADDR_W-1:0] t;
    @(posedge clk);
    if (rst) begin
      m_pc = RESET_VECTOR; m_epoch = '0; m_cnt = 0; m_started = 1'b0;
    end else begin
      fire = m_valid() && addr_ok;
      t    = m_tgt();
      if (fire)              m_pc = t + ADDR_W'(FETCH_BYTES);
      else if (flush)        m_pc = new_pc;
      else if (branch_valid) m_pc = branch_target;
      if (flush || branch_valid) m_epoch = m_epoch + 1'b1;
      if (fire && !resp_valid)                   m_cnt++;
      else if (resp_valid && !fire && m_cnt > 0) m_cnt--;
      m_started = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; branch_valid = 0; addr_ok = 0; resp_valid = 0;
    new_pc = '0; branch_target = '0;
  endtask

  task automatic drain();
    addr_ok = 0; resp_valid = 1;
    repeat (MAX_OUTST) tick();
    resp_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    tick(); tick(); #1;
    n_checks++;
    if (req_valid !== 1'b0 || outst_cnt !== 3'd0) begin
      n_fails++; $display("[TB] FAIL reset_state: valid=%b cnt=%0d, expected valid=0 cnt=0", req_valid, outst_cnt);
    end
    rst = 0; addr_ok = 1; #1;
    n_checks++;
    if (req_valid !== 1'b0) begin
      n_fails++; $display("[TB] FAIL reset_first_cycle: valid=%b, expected 0", req_valid);
    end
    tick(); #1;
    n_checks++;
    if (req_valid !== 1'b1 || req_pc !== 32'hbfc00000 || req_epoch !== 2'd0) begin
      n_fails++; $display("[TB] FAIL reset_first_fetch: v=%b pc=%h ep=%0d, expected v=1 pc=bfc00000 ep=0", req_valid, req_pc, req_epoch);
    end
    tick(); #1;
    n_checks++;
    if (req_pc !== 32'hbfc00004) begin
      n_fails++; $display("[TB] FAIL seq_pc1: pc=%h, expected bfc00004", req_pc);
    end
    tick(); #1;
    n_checks++;
    if (req_pc !== 32'hbfc00008 || req_epoch !== 2'd0) begin
      n_fails++; $display("[TB] FAIL seq_pc2: pc=%h ep=%0d, expected bfc00008 ep=0", req_pc, req_epoch);
    end
  endtask

  task automatic test_hold();
    addr_ok = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      n_checks++;
      if (req_valid !== 1'b1 || req_pc !== 32'hbfc00008) begin
        n_fails++; $display("[TB] FAIL hold_%0d: v=%b pc=%h, expected v=1 pc=bfc00008", i, req_valid, req_pc);
      end
    end
    addr_ok = 1;
    tick(); addr_ok = 0; #1;
    n_checks++;
    if (req_pc !== 32'hbfc0000c || outst_cnt !== 3'd3) begin
      n_fails++; $display("[TB] FAIL hold_release: pc=%h cnt=%0d, expected bfc0000c cnt=3", req_pc, outst_cnt);
    end
    drain();
  endtask

  task automatic test_branch();
    branch_valid = 1; branch_target = 32'h80001000; addr_ok = 1; #1;
    n_checks++;
    if (req_valid !== 1'b1 || req_pc !== 32'h80001000 || req_epoch !== 2'd1) begin
      n_fails++; $display("[TB] FAIL branch_bypass: v=%b pc=%h ep=%0d, expected v=1 pc=80001000 ep=1", req_valid, req_pc, req_epoch);
    end
    tick(); branch_valid = 0; #1;
    n_checks++;
    if (req_pc !== 32'h80001004 || req_epoch !== 2'd1) begin
      n_fails++; $display("[TB] FAIL branch_next: pc=%h ep=%0d, expected 80001004 ep=1", req_pc, req_epoch);
    end
    drain();
  endtask

  task automatic test_flush_branch();
    flush = 1; new_pc = 32'hbfc00380; branch_valid = 1; branch_target = 32'h80002000; #1;
    n_checks++;
    if (req_pc !== 32'hbfc00380 || req_epoch !== 2'd2) begin
      n_fails++; $display("[TB] FAIL flush_wins: pc=%h ep=%0d, expected bfc00380 ep=2", req_pc, req_epoch);
    end
    tick(); flush = 0; branch_valid = 0; #1;
    n_checks++;
    if (req_pc !== 32'hbfc00380 || req_epoch !== 2'd2) begin
      n_fails++; $display("[TB] FAIL flush_branch_lost: pc=%h ep=%0d, expected bfc00380 ep=2", req_pc, req_epoch);
    end
  endtask

  task automatic test_stall();
    stall = 1; branch_valid = 1; branch_target = 32'h80003000; #1;
    n_checks++;
    if (req_valid !== 1'b0) begin
      n_fails++; $display("[TB] FAIL stall_valid: v=%b, expected 0", req_valid);
    end
    tick(); branch_valid = 0; #1;
    n_checks++;
    if (req_valid !== 1'b0) begin
      n_fails++; $display("[TB] FAIL stall_hold: v=%b, expected 0", req_valid);
    end
    tick(); stall = 0; #1;
    n_checks++;
    if (req_valid !== 1'b1 || req_pc !== 32'h80003000 || req_epoch !== 2'd3) begin
      n_fails++; $display("[TB] FAIL stall_release: v=%b pc=%h ep=%0d, expected v=1 pc=80003000 ep=3", req_valid, req_pc, req_epoch);
    end
  endtask

  task automatic test_full_wrap();
    addr_ok = 1;
    repeat (4) tick();
    #1;
    n_checks++;
    if (req_valid !== 1'b0 || outst_cnt !== 3'd4) begin
      n_fails++; $display("[TB] FAIL full_block: v=%b cnt=%0d, expected v=0 cnt=4", req_valid, outst_cnt);
    end
    resp_valid = 1; tick(); resp_valid = 0; addr_ok = 0; #1;
    n_checks++;
    if (req_valid !== 1'b1 || outst_cnt !== 3'd3) begin
      n_fails++; $display("[TB] FAIL full_resume: v=%b cnt=%0d, expected v=1 cnt=3", req_valid, outst_cnt);
    end
    branch_valid = 1; branch_target = 32'hfffffffc; addr_ok = 1; resp_valid = 1; #1;
    n_checks++;
    if (req_pc !== 32'hfffffffc || req_epoch !== 2'd0) begin
      n_fails++; $display("[TB] FAIL wrap_issue: pc=%h ep=%0d, expected fffffffc ep=0", req_pc, req_epoch);
    end
    tick(); branch_valid = 0; addr_ok = 0; resp_valid = 0; #1;
    n_checks++;
    if (req_pc !== 32'h00000000 || outst_cnt !== 3'd3) begin
      n_fails++; $display("[TB] FAIL wrap_next: pc=%h cnt=%0d, expected 00000000 cnt=3", req_pc, outst_cnt);
    end
    branch_valid = 1; branch_target = 32'h80000002; #1;
    tick(); branch_valid = 0; #1;
    n_checks++;
    if (req_misalign !== 1'b1 || req_pc !== 32'h80000002 || req_epoch !== 2'd1) begin
      n_fails++; $display("[TB] FAIL misalign: mis=%b pc=%h ep=%0d, expected mis=1 pc=80000002 ep=1", req_misalign, req_pc, req_epoch);
    end
    drain();
  endtask

  task automatic test_underflow();
    resp_valid = 1; tick(); tick(); resp_valid = 0; #1;
    n_checks++;
    if (outst_cnt !== 3'd0) begin
      n_fails++; $display("[TB] FAIL underflow: cnt=%0d, expected 0", outst_cnt);
    end
  endtask

  task automatic test_random();
    logic [ADDR_W+EPOCH_W+1:0] got, exp;
    bit v;
    for (int i = 0; i < 600; i++) begin
      tick();
      rst           = ($urandom_range(0, 59) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      branch_valid  = ($urandom_range(0, 4) == 0);
      addr_ok       = ($urandom_range(0, 1) == 1);
      resp_valid    = ($urandom_range(0, 2) == 0);
      new_pc        = {$urandom} & ($urandom_range(0, 3) == 0 ? 32'hffffffff : 32'hfffffffc);
      branch_target = {$urandom} & ($urandom_range(0, 3) == 0 ? 32'hffffffff : 32'hfffffffc);
      #1;
      v   = m_valid();
      exp = {v, v && (m_tgt() & 32'h3) != 0, m_req_epoch(), m_tgt()};
      got = {req_valid, req_misalign, req_epoch, req_pc};
      n_checks++;
      if (got !== exp || outst_cnt !== CNT_W'(m_cnt)) begin
        n_fails++;
        $display("[TB] FAIL random_%0d: v/mis/ep/pc=%h cnt=%0d, expected %h cnt=%0d", i, got, outst_cnt, exp, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_branch();
    test_flush_branch();
    test_stall();
    drain();
    test_full_wrap();
    test_underflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
